// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT output streamer.
//   N_LOG2_DEF  : default transform size exponent (1024 points)
//   DATA_W      : width of one real or imaginary sample
//   BREV_MAX_W  : widest index the bit-reverse helper supports
//   state_e     : control FSM states
//   bit_reverse : reverses the low w bits of an index
package fft_stream_pkg;

  localparam int N_LOG2_DEF = 10;
  localparam int DATA_W     = 32;
  localparam int BREV_MAX_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Mirror all BREV_MAX_W bits, then shift so the reversed low w bits land
  // back at the bottom of the word.
  function automatic logic [BREV_MAX_W-1:0] bit_reverse(
    input logic [BREV_MAX_W-1:0] v,
    input int                    w
  );
    logic [BREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BREV_MAX_W; i++) begin
      r[i] = v[BREV_MAX_W-1-i];
    end
    return r >> (BREV_MAX_W - w);
  endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO holding returned samples until the stream sink accepts them.
//   i_clk, i_rst : clock, synchronous active-high reset (pointers/count only)
//   i_push       : write i_data (ignored when full unless popping)
//   i_pop        : drop head entry (ignored when empty)
//   o_data       : head entry, stable until popped
//   o_full       : both entries occupied
//   o_empty      : no entry occupied
module fft_skid_fifo #(
  parameter int PAYLOAD_W = 65
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_pop,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  logic [PAYLOAD_W-1:0] r_mem [2];
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fft_output_stream.sv
// Reads an N-point complex buffer (separate real/imag RAMs, 1-cycle read
// latency) and streams it out as 64-bit beats {imag, real} with TLAST on the
// final index. Block-level handshake follows ap_ctrl_chain.
//   ap_clk, ap_rst            : clock, synchronous active-high reset
//   ap_start, ap_continue     : start a run / acknowledge completion
//   ap_done, ap_idle, ap_ready: block status
//   IN_R_*, IN_I_*            : read ports of the real and imaginary buffers
//   OUT_T*                    : AXI-Stream master carrying the samples
import fft_stream_pkg::*;

module fft_output_stream #(
  parameter int N_LOG2        = N_LOG2_DEF,
  parameter bit REVERSE_ORDER = 1'b0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ap_start,
  input  logic                   ap_continue,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   ap_ready,
  output logic [N_LOG2-1:0]      IN_R_address0,
  output logic                   IN_R_ce0,
  input  logic [DATA_W-1:0]      IN_R_q0,
  output logic [N_LOG2-1:0]      IN_I_address0,
  output logic                   IN_I_ce0,
  input  logic [DATA_W-1:0]      IN_I_q0,
  output logic [2*DATA_W-1:0]    OUT_TDATA,
  output logic                   OUT_TVALID,
  input  logic                   OUT_TREADY,
  output logic                   OUT_TLAST
);

  localparam int PAYLOAD_W = 2*DATA_W + 1;

  state_e                r_state;
  logic [N_LOG2:0]       r_cnt;
  logic                  r_done_reg;
  logic                  r_vld_p1;
  logic                  r_last_p1;

  logic [N_LOG2-1:0]     w_idx;
  logic [N_LOG2-1:0]     w_rev;
  logic [N_LOG2-1:0]     w_addr;
  logic                  w_idx_last;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [PAYLOAD_W-1:0]  w_fifo_head;
  logic                  w_beat_hs;
  logic [1:0]            w_occ;
  logic [1:0]            w_pending;
  logic                  w_issue;

  assign w_idx      = r_cnt[N_LOG2-1:0];
  assign w_idx_last = &w_idx;
  assign w_rev      = N_LOG2'(bit_reverse(BREV_MAX_W'(w_idx), N_LOG2));
  assign w_addr     = REVERSE_ORDER ? w_rev : w_idx;

  assign w_beat_hs  = !w_fifo_empty && OUT_TREADY;
  assign w_occ      = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);

  // Credit counts the beat leaving this cycle so a free-flowing sink sees one
  // beat per clock while the FIFO can never be overrun.
  assign w_pending  = w_occ - {1'b0, w_beat_hs} + {1'b0, r_vld_p1};
  assign w_issue    = (r_state == S_RUN) && !r_cnt[N_LOG2] && (w_pending < 2'd2);

  assign IN_R_address0 = w_addr;
  assign IN_I_address0 = w_addr;
  assign IN_R_ce0      = w_issue;
  assign IN_I_ce0      = w_issue;

  assign OUT_TVALID = !w_fifo_empty;
  assign OUT_TDATA  = w_fifo_head[2*DATA_W-1:0];
  assign OUT_TLAST  = !w_fifo_empty && w_fifo_head[PAYLOAD_W-1];

  assign ap_done  = (r_state == S_DONE) || r_done_reg;
  assign ap_ready = (r_state == S_DONE);
  assign ap_idle  = (r_state == S_IDLE) && !ap_start;

  // p0 -> p1: read issued, RAM data returns next cycle
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_done_reg <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_last_p1  <= 1'b0;
    end else begin
      r_vld_p1   <= w_issue;
      r_last_p1  <= w_issue && w_idx_last;
      r_done_reg <= (r_done_reg || (r_state == S_DONE)) && !ap_continue;
      case (r_state)
        S_IDLE: begin
          if (ap_start && !r_done_reg) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_idx_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_beat_hs && w_fifo_head[PAYLOAD_W-1]) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // p1 -> p2: returned sample queued for the stream
  fft_skid_fifo #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_fifo (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_push  (r_vld_p1),
    .i_data  ({r_last_p1, IN_I_q0, IN_R_q0}),
    .i_pop   (OUT_TREADY),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_fft_output_stream.sv
module tb_fft_output_stream;

  logic clk = 1'b0;
  logic rst, start, cont, tready;

  logic        a_done, a_idle, a_ready, a_r_ce, a_i_ce, a_tvalid, a_tlast;
  logic [9:0]  a_r_addr, a_i_addr;
  logic [31:0] a_rq, a_iq;
  logic [63:0] a_tdata;

  logic        b_done, b_idle, b_ready, b_r_ce, b_i_ce, b_tvalid, b_tlast;
  logic [9:0]  b_r_addr, b_i_addr;
  logic [31:0] b_rq, b_iq;
  logic [63:0] b_tdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_output_stream #(.N_LOG2(10), .REVERSE_ORDER(1'b0)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_continue(cont),
    .ap_done(a_done), .ap_idle(a_idle), .ap_ready(a_ready),
    .IN_R_address0(a_r_addr), .IN_R_ce0(a_r_ce), .IN_R_q0(a_rq),
    .IN_I_address0(a_i_addr), .IN_I_ce0(a_i_ce), .IN_I_q0(a_iq),
    .OUT_TDATA(a_tdata), .OUT_TVALID(a_tvalid), .OUT_TREADY(tready), .OUT_TLAST(a_tlast)
  );

  fft_output_stream #(.N_LOG2(10), .REVERSE_ORDER(1'b1)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_continue(cont),
    .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_ready),
    .IN_R_address0(b_r_addr), .IN_R_ce0(b_r_ce), .IN_R_q0(b_rq),
    .IN_I_address0(b_i_addr), .IN_I_ce0(b_i_ce), .IN_I_q0(b_iq),
    .OUT_TDATA(b_tdata), .OUT_TVALID(b_tvalid), .OUT_TREADY(tready), .OUT_TLAST(b_tlast)
  );

  // Buffers preloaded with real[i] = i, imag[i] = ~i, 1-cycle read latency.
  always @(posedge clk) begin
    if (a_r_ce) a_rq <= 32'(a_r_addr);
    if (a_i_ce) a_iq <= ~32'(a_i_addr);
    if (b_r_ce) b_rq <= 32'(b_r_addr);
    if (b_i_ce) b_iq <= ~32'(b_i_addr);
  end

  // Beat recorder and stall-stability watcher.
  logic [63:0] beats_a [8192];
  logic        last_a  [8192];
  logic [63:0] beats_b [8192];
  logic        last_b  [8192];
  int          na = 0, nb = 0, reads_a = 0, stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (a_tvalid && tready) begin
        beats_a[na] <= a_tdata; last_a[na] <= a_tlast; na <= na + 1;
      end
      if (b_tvalid && tready) begin
        beats_b[nb] <= b_tdata; last_b[nb] <= b_tlast; nb <= nb + 1;
      end
      if (a_r_ce) reads_a <= reads_a + 1;
      if (prev_stall && (a_tdata !== prev_data || a_tlast !== prev_last))
        stab_viol <= stab_viol + 1;
      prev_stall <= a_tvalid && !tready;
      prev_data  <= a_tdata;
      prev_last  <= a_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = -1;
    for (int e = 1; e <= bound; e++) begin
      tick();
      if (a_done) begin
        cycles = e;
        break;
      end
    end
  endtask

  task automatic clear_done();
    cont = 1'b1;
    tick();
    cont = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cont = 1'b0; tready = 1'b0;
    repeat (3) tick();
    n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", a_tvalid); end
    n_checks++; if (a_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", a_tlast); end
    n_checks++; if (a_r_ce !== 1'b0 || a_i_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b%b want 00", a_r_ce, a_i_ce); end
    n_checks++; if (a_r_addr !== 10'd0 || a_i_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d/%0d want 0", a_r_addr, a_i_addr); end
    n_checks++; if (a_done !== 1'b0 || a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_done_ready: got %b%b want 00", a_done, a_ready); end
    n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", a_idle); end
    n_checks++; if (b_tvalid !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_outputs: got %b%b%b want 000", b_tvalid, b_done, b_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (a_idle !== 1'b1 || b_idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %b%b want 11", a_idle, b_idle); end
    n_checks++; if (a_r_ce !== 1'b0) begin n_fail++; $display("FAIL idle_no_read: got %b want 0", a_r_ce); end
  endtask

  task automatic test_stream();
    int base_a, base_b, first_v, done_e, bad, badlast;
    logic [31:0] kk;
    logic [63:0] exp;
    base_a = na; base_b = nb; first_v = -1; done_e = -1; bad = 0; badlast = 0;
    tready = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_checks++; if (a_r_ce !== 1'b1 || a_r_addr !== 10'd0) begin n_fail++; $display("FAIL first_read: got ce=%b addr=%0d want ce=1 addr=0", a_r_ce, a_r_addr); end
    for (int e = 1; e <= 1100; e++) begin
      tick();
      if (e == 1) begin
        n_checks++; if (b_r_addr !== 10'd512) begin n_fail++; $display("FAIL rev_addr1: got %0d want 512", b_r_addr); end
      end
      if (first_v < 0 && a_tvalid) first_v = e;
      if (a_done) begin done_e = e; break; end
    end
    n_checks++; if (first_v != 2) begin n_fail++; $display("FAIL first_tvalid_cycle: got %0d want 2", first_v); end
    n_checks++; if (done_e != 1026) begin n_fail++; $display("FAIL done_cycle: got %0d want 1026", done_e); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL ready_with_done: got %b want 1", a_ready); end
    n_checks++; if (na - base_a != 1024) begin n_fail++; $display("FAIL beat_count: got %0d want 1024", na - base_a); end
    for (int k = 0; k < 1024; k++) begin
      kk  = 32'(k);
      exp = {~kk, kk};
      if (beats_a[base_a+k] !== exp) bad++;
      if (last_a[base_a+k] !== (k == 1023)) badlast++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL beat_data: got %0d bad beats want 0", bad); end
    n_checks++; if (badlast != 0) begin n_fail++; $display("FAIL tlast_position: got %0d bad beats want 0", badlast); end
    n_checks++; if (nb - base_b != 1024) begin n_fail++; $display("FAIL rev_beat_count: got %0d want 1024", nb - base_b); end
    n_checks++; if (beats_b[base_b+1] !== {~32'd512, 32'd512}) begin n_fail++; $display("FAIL rev_beat1: got %h want %h", beats_b[base_b+1], {~32'd512, 32'd512}); end
    n_checks++; if (beats_b[base_b+2] !== {~32'd256, 32'd256}) begin n_fail++; $display("FAIL rev_beat2: got %h want %h", beats_b[base_b+2], {~32'd256, 32'd256}); end
    n_checks++; if (beats_b[base_b+1023] !== {~32'd1023, 32'd1023} || last_b[base_b+1023] !== 1'b1) begin n_fail++; $display("FAIL rev_last_beat: got %h/%b want %h/1", beats_b[base_b+1023], last_b[base_b+1023], {~32'd1023, 32'd1023}); end
    tick();
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL done_held: got %b want 1", a_done); end
    clear_done();
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL done_cleared: got %b want 0", a_done); end
  endtask

  task automatic test_stall();
    int base, r0, c, bad;
    logic [31:0] kk;
    base = na; r0 = reads_a; bad = 0;
    tready = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (50) tick();
    n_checks++; if (reads_a - r0 != 2) begin n_fail++; $display("FAIL stall_reads: got %0d want 2", reads_a - r0); end
    n_checks++; if (a_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_tvalid: got %b want 1", a_tvalid); end
    n_checks++; if (a_tdata !== {~32'd0, 32'd0}) begin n_fail++; $display("FAIL stall_tdata: got %h want %h", a_tdata, {~32'd0, 32'd0}); end
    n_checks++; if (na != base) begin n_fail++; $display("FAIL stall_no_beats: got %0d want 0", na - base); end
    tready = 1'b1;
    wait_done(1300, c);
    n_checks++; if (c < 0) begin n_fail++; $display("FAIL stall_done_timeout: got %0d want >0", c); end
    n_checks++; if (na - base != 1024) begin n_fail++; $display("FAIL stall_beat_count: got %0d want 1024", na - base); end
    n_checks++; if (reads_a - r0 != 1024) begin n_fail++; $display("FAIL stall_total_reads: got %0d want 1024", reads_a - r0); end
    for (int k = 0; k < 1024; k++) begin
      kk = 32'(k);
      if (beats_a[base+k] !== {~kk, kk}) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_beat_data: got %0d bad want 0", bad); end
    n_checks++; if (stab_viol != 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes want 0", stab_viol); end
    clear_done();
  endtask

  task automatic test_random_ready();
    int base, done_e, bad, badlast;
    logic [31:0] kk;
    base = na; done_e = -1; bad = 0; badlast = 0;
    tready = 1'($urandom_range(0, 1));
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int e = 1; e <= 6000; e++) begin
      tready = 1'($urandom_range(0, 1));
      tick();
      if (a_done) begin done_e = e; break; end
    end
    tready = 1'b1;
    n_checks++; if (done_e < 0) begin n_fail++; $display("FAIL rand_done_timeout: got %0d want >0", done_e); end
    n_checks++; if (na - base != 1024) begin n_fail++; $display("FAIL rand_handshakes: got %0d want 1024", na - base); end
    for (int k = 0; k < 1024; k++) begin
      kk = 32'(k);
      if (beats_a[base+k] !== {~kk, kk}) bad++;
      if (last_a[base+k] !== (k == 1023)) badlast++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_beat_data: got %0d bad want 0", bad); end
    n_checks++; if (badlast != 0) begin n_fail++; $display("FAIL rand_tlast: got %0d bad want 0", badlast); end
    n_checks++; if (stab_viol != 0) begin n_fail++; $display("FAIL rand_stability: got %0d changes want 0", stab_viol); end
    clear_done();
  endtask

  task automatic test_continue_hold();
    int c, r0, hold_bad;
    hold_bad = 0;
    tready = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(1200, c);
    n_checks++; if (c < 0) begin n_fail++; $display("FAIL hold_run_timeout: got %0d want >0", c); end
    start = 1'b1;
    r0 = reads_a;
    repeat (20) begin
      tick();
      if (a_done !== 1'b1) hold_bad++;
    end
    n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL hold_done_high: got %0d low cycles want 0", hold_bad); end
    n_checks++; if (reads_a != r0) begin n_fail++; $display("FAIL hold_no_reads: got %0d want 0", reads_a - r0); end
    cont = 1'b1;
    tick();
    cont = 1'b0;
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL continue_clears: got %b want 0", a_done); end
    tick();
    n_checks++; if (a_r_ce !== 1'b1 || a_r_addr !== 10'd0) begin n_fail++; $display("FAIL restart_read: got ce=%b addr=%0d want ce=1 addr=0", a_r_ce, a_r_addr); end
    start = 1'b0;
    wait_done(1200, c);
    n_checks++; if (c < 0) begin n_fail++; $display("FAIL restart_done_timeout: got %0d want >0", c); end
    clear_done();
  endtask

  task automatic test_reset_mid();
    int base, base2, c;
    base = na;
    tready = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int e = 0; e < 400; e++) begin
      tick();
      if (na - base >= 300) break;
    end
    n_checks++; if (na - base != 300) begin n_fail++; $display("FAIL mid_reach_300: got %0d want 300", na - base); end
    rst = 1'b1;
    tick();
    n_checks++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tvalid: got %b%b want 00", a_tvalid, a_tlast); end
    n_checks++; if (a_r_ce !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ce_done: got %b%b want 00", a_r_ce, a_done); end
    rst = 1'b0;
    tick();
    n_checks++; if (a_idle !== 1'b1 || a_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: got idle=%b tvalid=%b want 1/0", a_idle, a_tvalid); end
    base2 = na;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1200, c);
    n_checks++; if (c < 0) begin n_fail++; $display("FAIL mid_rerun_timeout: got %0d want >0", c); end
    n_checks++; if (beats_a[base2] !== {~32'd0, 32'd0}) begin n_fail++; $display("FAIL mid_rerun_beat0: got %h want %h", beats_a[base2], {~32'd0, 32'd0}); end
    n_checks++; if (na - base2 != 1024) begin n_fail++; $display("FAIL mid_rerun_count: got %0d want 1024", na - base2); end
    clear_done();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_random_ready();
    test_continue_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
